alu_seq: RTL and testbench

Parametrised, registered successor to the 16-bit combinational ALU, for use in the datapath behind the register file. It keeps the 16 base opcodes and the 5-bit status layout. It adds carry-chained ADC/SBC, using a stored carry flag, and iterative multi-cycle MUL/DIV/MOD, driven by a start/busy/done handshake. Results and flags are registered and held until the next completed operation.

---
 rtl/alu_seq_pkg.sv | 48 ++++
 rtl/alu_seq_iter.sv | 85 ++++++++
 rtl/alu_seq.sv | 216 +++++++++++++++++++++
 tb/tb_alu_seq.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared opcodes, flag positions and FSM states for the sequential ALU
package alu_seq_pkg;

  typedef enum logic [4:0] {
    OP_ADD = 5'd0,
    OP_SUB = 5'd1,
    OP_NEG = 5'd2,
    OP_INC = 5'd3,
    OP_DEC = 5'd4,
    OP_MOV = 5'd5,
    OP_AND = 5'd6,
    OP_OR  = 5'd7,
    OP_XOR = 5'd8,
    OP_NOT = 5'd9,
    OP_ASR = 5'd10,
    OP_ASL = 5'd11,
    OP_LSR = 5'd12,
    OP_LSL = 5'd13,
    OP_CSR = 5'd14,
    OP_CSL = 5'd15,
    OP_ADC = 5'd16,
    OP_SBC = 5'd17,
    OP_MUL = 5'd18,
    OP_DIV = 5'd19,
    OP_MOD = 5'd20
  } opcode_e;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;
  localparam int FLAG_P = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ITER = 1'b1
  } state_e;

  function automatic logic is_iter_op(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

  // Opcodes above MOD are reserved and behave as NOPs.
  function automatic logic is_nop_op(input logic [4:0] op);
    return op > OP_MOD;
  endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// rtl/alu_seq_iter.sv - shift-add multiplier and restoring divider on one shared accumulator
module alu_seq_iter
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             div_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam int M  = WIDTH - 1;

  logic             run_q;
  logic             div_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] opd_q;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] acc_n;
  logic [WIDTH-1:0] lo_n;

  // acc holds the product high half or the partial remainder; lo holds the
  // multiplier being consumed or the dividend being replaced by quotient bits.
  always_comb begin
    sum     = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
    shifted = {acc_q, lo_q[M]};
    diff    = shifted - {1'b0, opd_q};
    if (div_q) begin
      if (diff[WIDTH]) begin
        acc_n = shifted[M:0];
        lo_n  = {lo_q[M-1:0], 1'b0};
      end else begin
        acc_n = diff[M:0];
        lo_n  = {lo_q[M-1:0], 1'b1};
      end
    end else begin
      acc_n = sum[WIDTH:1];
      lo_n  = {sum[0], lo_q[M:1]};
    end
  end

  // The final step result is offered combinationally so the caller can
  // register it on the same edge that finishes the last iteration.
  assign done = run_q && (cnt_q == CW'(WIDTH - 1));
  assign hi   = acc_n;
  assign lo   = lo_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= 1'b0;
      div_q <= 1'b0;
      cnt_q <= '0;
      acc_q <= '0;
      lo_q  <= '0;
      opd_q <= '0;
    end else if (start) begin
      run_q <= 1'b1;
      div_q <= div_mode;
      cnt_q <= '0;
      acc_q <= '0;
      lo_q  <= a;
      opd_q <= b;
    end else if (run_q) begin
      acc_q <= acc_n;
      lo_q  <= lo_n;
      cnt_q <= cnt_q + 1'b1;
      if (done) begin
        run_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with carry-chained add/sub and iterative mul/div/mod
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic [4:0]       status
);

  localparam int SHW = $clog2(WIDTH);
  localparam int M   = WIDTH - 1;
  localparam logic [WIDTH:0]   ONE_EXT = (WIDTH + 1)'(1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH - 1){1'b0}}};
  localparam logic [SHW:0]     W_SH    = (SHW + 1)'(WIDTH);

  state_e           state;
  state_e           state_n;
  opcode_e          op_e;
  opcode_e          op_q;
  logic             bz_q;
  logic             carry_q;

  logic             accept;
  logic             iter_go;
  logic             wr_en;
  logic             done_n;

  logic             it_done;
  logic [WIDTH-1:0] it_hi;
  logic [WIDTH-1:0] it_lo;

  logic [SHW-1:0]   sh;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   shl;
  logic [WIDTH-1:0] r_s;
  logic             c_s;
  logic             v_s;
  logic [WIDTH-1:0] r_i;
  logic             c_i;
  logic             v_i;
  logic [WIDTH-1:0] r_w;
  logic             c_w;
  logic             v_w;
  logic [4:0]       flags_w;

  assign op_e = opcode_e'(opcode);
  assign sh   = b[SHW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (iter_go) state_n = ST_ITER;
      ST_ITER: if (it_done) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state == ST_ITER);
    accept  = (state == ST_IDLE) && start;
    iter_go = accept && is_iter_op(opcode);
    wr_en   = (accept && !is_iter_op(opcode) && !is_nop_op(opcode)) ||
              (busy && it_done);
    done_n  = (accept && !is_iter_op(opcode)) || (busy && it_done);
  end

  alu_seq_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk      (clk),
    .rst      (rst),
    .start    (iter_go),
    .div_mode (op_e != OP_MUL),
    .a        (a),
    .b        (b),
    .done     (it_done),
    .hi       (it_hi),
    .lo       (it_lo)
  );

  // Single-cycle results; C is carry-out for adds and borrow for subtracts.
  always_comb begin
    sum_ext = '0;
    shl     = {1'b0, a} << sh;
    r_s     = '0;
    c_s     = 1'b0;
    v_s     = 1'b0;
    case (op_e)
      OP_ADD: begin
        sum_ext = {1'b0, a} + {1'b0, b};
        r_s     = sum_ext[M:0];
        c_s     = sum_ext[WIDTH];
        v_s     = (a[M] == b[M]) && (r_s[M] != a[M]);
      end
      OP_ADC: begin
        sum_ext = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_q};
        r_s     = sum_ext[M:0];
        c_s     = sum_ext[WIDTH];
        v_s     = (a[M] == b[M]) && (r_s[M] != a[M]);
      end
      OP_SUB: begin
        sum_ext = {1'b0, a} - {1'b0, b};
        r_s     = sum_ext[M:0];
        c_s     = sum_ext[WIDTH];
        v_s     = (a[M] != b[M]) && (r_s[M] != a[M]);
      end
      OP_SBC: begin
        sum_ext = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, carry_q};
        r_s     = sum_ext[M:0];
        c_s     = sum_ext[WIDTH];
        v_s     = (a[M] != b[M]) && (r_s[M] != a[M]);
      end
      OP_NEG: begin
        r_s = '0 - a;
        v_s = (a == MIN_NEG);
      end
      OP_INC: begin
        sum_ext = {1'b0, a} + ONE_EXT;
        r_s     = sum_ext[M:0];
        c_s     = sum_ext[WIDTH];
        v_s     = !a[M] && r_s[M];
      end
      OP_DEC: begin
        sum_ext = {1'b0, a} - ONE_EXT;
        r_s     = sum_ext[M:0];
        c_s     = sum_ext[WIDTH];
        v_s     = a[M] && !r_s[M];
      end
      OP_MOV: r_s = a;
      OP_AND: r_s = a & b;
      OP_OR:  r_s = a | b;
      OP_XOR: r_s = a ^ b;
      OP_NOT: r_s = ~a;
      OP_ASR: r_s = $signed(a) >>> sh;
      OP_LSR: r_s = a >> sh;
      OP_ASL, OP_LSL: begin
        r_s = shl[M:0];
        c_s = shl[WIDTH];
      end
      OP_CSR: r_s = (a >> sh) | (a << (W_SH - {1'b0, sh}));
      OP_CSL: r_s = (a << sh) | (a >> (W_SH - {1'b0, sh}));
      default: r_s = '0;
    endcase
  end

  // A zero divisor falls out of the restoring divider as quotient all ones
  // and remainder equal to the dividend; only V needs flagging here.
  always_comb begin
    r_i = it_lo;
    c_i = 1'b0;
    v_i = 1'b0;
    case (op_q)
      OP_MUL: begin
        c_i = |it_hi;
        v_i = |it_hi;
      end
      OP_MOD: begin
        r_i = it_hi;
        v_i = bz_q;
      end
      default: v_i = bz_q;
    endcase
  end

  always_comb begin
    r_w              = busy ? r_i : r_s;
    c_w              = busy ? c_i : c_s;
    v_w              = busy ? v_i : v_s;
    flags_w          = '0;
    flags_w[FLAG_C]  = c_w;
    flags_w[FLAG_Z]  = (r_w == '0);
    flags_w[FLAG_N]  = r_w[M];
    flags_w[FLAG_V]  = v_w;
    flags_w[FLAG_P]  = ~^r_w;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y       <= '0;
      status  <= '0;
      done    <= 1'b0;
      carry_q <= 1'b0;
      op_q    <= OP_MUL;
      bz_q    <= 1'b0;
    end else begin
      done <= done_n;
      if (iter_go) begin
        op_q <= op_e;
        bz_q <= (b == '0);
      end
      if (wr_en) begin
        y       <= r_w;
        status  <= flags_w;
        carry_q <= c_w;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed vectors, corner sequences and random ops against a reference model
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  opcode = '0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy;
  logic        done;
  logic [15:0] y;
  logic [4:0]  status;

  int n_checks = 0;
  int n_fail   = 0;

  alu_seq #(.WIDTH(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .opcode (opcode),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .y      (y),
    .status (status)
  );

  always #5 clk = ~clk;

  typedef struct {
    int op;
    int va;
    int vb;
    int ey;
    int est;
  } vec_t;

  typedef struct {
    int y;
    int st;
    int c;
    int lat;
  } res_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic int sgn(input int x);
    return (x & 'h8000) != 0 ? x - 65536 : x;
  endfunction

  function automatic bit ovf(input int s);
    return (s > 32767) || (s < -32768);
  endfunction

  function automatic res_t model(input int op, input int ua, input int ub, input int cin,
                                 input int py, input int pst);
    res_t   r;
    int     sa, sb, sh, full, yy;
    longint p;
    bit     c, v, upd;
    sa = sgn(ua); sb = sgn(ub); sh = ub % 16;
    c = 0; v = 0; upd = 1; full = 0; r.lat = 1;
    case (op)
      0:  begin full = ua + ub; c = full > 'hFFFF; v = ovf(sa + sb); end
      1:  begin full = ua - ub; c = ua < ub; v = ovf(sa - sb); end
      2:  begin full = -ua; v = ovf(-sa); end
      3:  begin full = ua + 1; c = full > 'hFFFF; v = ovf(sa + 1); end
      4:  begin full = ua - 1; c = ua == 0; v = ovf(sa - 1); end
      5:  full = ua;
      6:  full = ua & ub;
      7:  full = ua | ub;
      8:  full = ua ^ ub;
      9:  full = ~ua;
      10: full = sa >>> sh;
      11, 13: begin
        full = ua << sh;
        c = (sh != 0) && (((ua >> (16 - sh)) & 1) == 1);
      end
      12: full = ua >> sh;
      14: full = (ua >> sh) | (ua << (16 - sh));
      15: full = (ua << sh) | (ua >> (16 - sh));
      16: begin full = ua + ub + cin; c = full > 'hFFFF; v = ovf(sa + sb + cin); end
      17: begin full = ua - ub - cin; c = ua < ub + cin; v = ovf(sa - sb - cin); end
      18: begin
        p = longint'(ua) * longint'(ub);
        full = int'(p & 'hFFFF); c = (p >> 16) != 0; v = c; r.lat = 17;
      end
      19: begin r.lat = 17; if (ub == 0) begin full = 'hFFFF; v = 1; end else full = ua / ub; end
      20: begin r.lat = 17; if (ub == 0) begin full = ua; v = 1; end else full = ua % ub; end
      default: upd = 0;
    endcase
    if (!upd) begin
      r.y = py; r.st = pst; r.c = cin;
    end else begin
      yy = full & 'hFFFF;
      r.y = yy;
      r.c = c;
      r.st = (($countones(yy) % 2 == 0) ? 16 : 0) | (v ? 8 : 0) |
             (((yy >> 15) & 1) << 2) | ((yy == 0) ? 2 : 0) | (c ? 1 : 0);
    end
    return r;
  endfunction

  task automatic run_op(input int op, input int ua, input int ub, output int lat);
    @(negedge clk);
    start = 1'b1; opcode = 5'(op); a = 16'(ua); b = 16'(ub);
    @(posedge clk); #1;
    start = 1'b0; opcode = 5'($urandom); a = 16'($urandom); b = 16'($urandom);
    lat = 1;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  vec_t vt[20];

  initial begin
    int   lat, bcnt, ym, cm, stm, op, ua, ub, sel;
    bit   got_done, any_done;
    res_t e;

    vt[0]  = '{0,  'h7FFF, 'h0001, 'h8000, 'b01100};
    vt[1]  = '{0,  'hFFFF, 'h0001, 'h0000, 'b10011};
    vt[2]  = '{16, 'h0001, 'h0001, 'h0003, 'b10000};
    vt[3]  = '{18, 'h0100, 'h0100, 'h0000, 'b11011};
    vt[4]  = '{19, 100,    7,      'h000E, 'b00000};
    vt[5]  = '{20, 100,    7,      'h0002, 'b00000};
    vt[6]  = '{19, 5,      0,      'hFFFF, 'b11100};
    vt[7]  = '{20, 5,      0,      'h0005, 'b11000};
    vt[8]  = '{13, 'h8001, 1,      'h0002, 'b00001};
    vt[9]  = '{15, 'h8001, 4,      'h0018, 'b10000};
    vt[10] = '{10, 'h8000, 15,     'hFFFF, 'b10100};
    vt[11] = '{2,  'h8000, 0,      'h8000, 'b01100};
    vt[12] = '{1,  'h0000, 'h0001, 'hFFFF, 'b10101};
    vt[13] = '{25, 'h1234, 'h5678, 'hFFFF, 'b10101};
    vt[14] = '{16, 'h0001, 'h0001, 'h0003, 'b10000};
    vt[15] = '{13, 'h1234, 0,      'h1234, 'b00000};
    vt[16] = '{4,  'h0000, 0,      'hFFFF, 'b10101};
    vt[17] = '{17, 'h0005, 'h0002, 'h0002, 'b00000};
    vt[18] = '{3,  'h7FFF, 0,      'h8000, 'b01100};
    vt[19] = '{18, 'hFFFF, 'hFFFF, 'h0001, 'b01001};

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_y", y, 0);
    check("reset_status", status, 0);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      run_op(vt[i].op, vt[i].va, vt[i].vb, lat);
      check($sformatf("vec%0d_y", i), y, vt[i].ey);
      check($sformatf("vec%0d_status", i), status, vt[i].est);
      check($sformatf("vec%0d_latency", i), lat, (vt[i].op >= 18 && vt[i].op <= 20) ? 17 : 1);
    end

    // MUL with a stray start mid-operation: ignored, not queued.
    ym = y;
    @(negedge clk); start = 1'b1; opcode = 5'd18; a = 16'd3; b = 16'd5;
    @(posedge clk); #1; start = 1'b0;
    bcnt = 0; got_done = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) begin got_done = 1; break; end
      if (busy) bcnt++;
      if (k == 4) begin
        check("mid_op_y_hold", y, ym);
        start = 1'b1; opcode = 5'd0; a = 16'd1; b = 16'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("mul_done_seen", got_done, 1);
    check("mul_busy_cycles", bcnt, 16);
    check("mul_y", y, 15);
    check("mul_status", status, 'b10000);
    any_done = 0;
    repeat (3) begin @(posedge clk); #1; if (done) any_done = 1; end
    check("no_queued_op", any_done, 0);
    check("y_after_ignored_start", y, 15);

    // Start accepted in the same cycle that done is high.
    @(negedge clk); start = 1'b1; opcode = 5'd19; a = 16'd100; b = 16'd7;
    @(posedge clk); #1; start = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin @(posedge clk); #1; end
    check("b2b_first_done", done, 1);
    check("b2b_first_y", y, 14);
    start = 1'b1; opcode = 5'd0; a = 16'h0010; b = 16'h0020;
    @(posedge clk); #1; start = 1'b0;
    check("b2b_second_done", done, 1);
    check("b2b_second_y", y, 'h30);

    // Reset in the middle of a MUL clears everything, including stored carry.
    run_op(1, 0, 1, lat);
    check("pre_reset_y", y, 'hFFFF);
    @(negedge clk); start = 1'b1; opcode = 5'd18; a = 16'h0100; b = 16'h0100;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_y", y, 0);
    check("rst_mid_status", status, 0);
    @(negedge clk) rst = 1'b0;
    any_done = 0;
    repeat (20) begin @(posedge clk); #1; if (done || busy) any_done = 1; end
    check("rst_no_resume", any_done, 0);
    run_op(16, 1, 1, lat);
    check("rst_carry_cleared_y", y, 2);
    check("rst_carry_cleared_status", status, 0);

    ym = 2; stm = 0; cm = 0;
    for (int i = 0; i < 150; i++) begin
      op = int'($urandom_range(0, 31));
      ua = int'($urandom & 'hFFFF);
      sel = int'($urandom_range(0, 7));
      ub = (sel == 0) ? 0 : (sel < 3) ? int'($urandom_range(0, 17)) : int'($urandom & 'hFFFF);
      e = model(op, ua, ub, cm, ym, stm);
      run_op(op, ua, ub, lat);
      check($sformatf("rnd%0d_op%0d_y", i, op), y, e.y);
      check($sformatf("rnd%0d_op%0d_status", i, op), status, e.st);
      check($sformatf("rnd%0d_op%0d_latency", i, op), lat, e.lat);
      ym = e.y; stm = e.st; cm = e.c;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
